// File: rtl/tempo_pkg.sv
// Shared types, widths and BPM limits for the tap-tempo detector and the speed bus.
package tempo_pkg;

  typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE} state_t;

  localparam int unsigned INTERVAL_W = 11;
  localparam int unsigned SUM_W      = 13;
  localparam int unsigned NUM_W      = 18;
  localparam int unsigned SPEED_W    = 8;
  localparam int unsigned HIST_DEPTH = 4;

  localparam int unsigned DEF_BPM_MIN   = 30;
  localparam int unsigned DEF_BPM_MAX   = 250;
  localparam int unsigned DEF_BPM_RESET = 60;

  // Saturate a divider quotient onto the 8-bit speed bus.
  function automatic logic [SPEED_W-1:0] clamp_bpm(input logic [NUM_W-1:0] q,
                                                   input int unsigned    lo,
                                                   input int unsigned    hi);
    if (q < NUM_W'(lo)) return SPEED_W'(lo);
    if (q > NUM_W'(hi)) return SPEED_W'(hi);
    return SPEED_W'(q);
  endfunction

endpackage

// File: rtl/tap_tempo_if.sv
// Tap input and speed-bus outputs of the tap-tempo detector.
interface tap_tempo_if;
  import tempo_pkg::*;

  logic               tap;
  logic [SPEED_W-1:0] speed;
  logic               speed_valid;
  logic               locked;
  logic               tap_seen;

  modport master (output tap, input speed, input speed_valid, input locked, input tap_seen);
  modport slave  (input tap, output speed, output speed_valid, output locked, output tap_seen);
endinterface

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; a zero divisor yields all-ones.
module seq_divider #(
  parameter int unsigned NUM_WIDTH = 18,
  parameter int unsigned DEN_WIDTH = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_WIDTH-1:0] num,
  input  logic [DEN_WIDTH-1:0] den,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_WIDTH-1:0] quo
);

  localparam int unsigned CNT_W = $clog2(NUM_WIDTH + 1);

  logic [DEN_WIDTH-1:0] rem;
  logic [DEN_WIDTH-1:0] den_q;
  logic [CNT_W-1:0]     cnt;
  logic [DEN_WIDTH:0]   rem_sh_c;
  logic [DEN_WIDTH+1:0] diff_c;
  logic                 fits_c;

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    rem_sh_c = {rem, quo[NUM_WIDTH-1]};
    diff_c   = {1'b0, rem_sh_c} - {2'b00, den_q};
    fits_c   = ~diff_c[DEN_WIDTH+1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem   <= '0;
      den_q <= '0;
      quo   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        rem   <= '0;
        den_q <= den;
        quo   <= num;
        cnt   <= CNT_W'(NUM_WIDTH);
        busy  <= 1'b1;
      end else if (busy) begin
        quo <= {quo[NUM_WIDTH-2:0], fits_c};
        rem <= fits_c ? DEN_WIDTH'(diff_c) : DEN_WIDTH'(rem_sh_c);
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tap_tempo.sv
// Tap-tempo detector: times debounced taps in ms ticks and turns the average of
// the last few intervals into a clamped BPM value on the speed bus.
module tap_tempo
  import tempo_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 25_000_000,
  parameter int unsigned TICK_HZ        = 1000,
  parameter int unsigned DEBOUNCE_TICKS = 10,
  parameter int unsigned TIMEOUT_TICKS  = 2000,
  parameter int unsigned BPM_MIN        = DEF_BPM_MIN,
  parameter int unsigned BPM_MAX        = DEF_BPM_MAX,
  parameter int unsigned BPM_RESET      = DEF_BPM_RESET
) (
  input  logic        clk,
  input  logic        rst,
  tap_tempo_if.slave  bus
);

  localparam int unsigned PRESC   = CLK_HZ / TICK_HZ;
  localparam int unsigned PRESC_W = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int unsigned N_W     = $clog2(HIST_DEPTH + 1);
  localparam int unsigned BPM_NUM = 60 * TICK_HZ;

  logic                  tap_s1, tap_s2, tap_d;
  logic                  rise_c, tap_acc_c;
  logic [PRESC_W-1:0]    presc;
  logic                  tick_c;
  logic [INTERVAL_W-1:0] ivl;
  logic                  armed;

  state_t                state;
  logic [INTERVAL_W-1:0] hist [HIST_DEPTH];
  logic [N_W-1:0]        n;
  logic                  div_start, div_busy, div_done;
  logic [NUM_W-1:0]      div_num, div_quo;
  logic [SUM_W-1:0]      div_den;

  logic [SPEED_W-1:0]    speed;
  logic                  speed_valid, locked, tap_seen;

  // Two-flop synchronizer plus edge register on the raw button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_s1 <= 1'b0;
      tap_s2 <= 1'b0;
      tap_d  <= 1'b0;
    end else begin
      tap_s1 <= bus.tap;
      tap_s2 <= tap_s1;
      tap_d  <= tap_s2;
    end
  end

  assign rise_c    = tap_s2 & ~tap_d;
  // The very first tap after reset has nothing to be locked out against.
  assign tap_acc_c = rise_c && (!armed || (ivl >= INTERVAL_W'(DEBOUNCE_TICKS)));
  assign tick_c    = (presc == PRESC_W'(PRESC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) presc <= '0;
    else     presc <= tick_c ? '0 : presc + PRESC_W'(1);
  end

  // Interval counter doubles as the debounce lockout timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ivl   <= '0;
      armed <= 1'b0;
    end else if (tap_acc_c) begin
      ivl   <= '0;
      armed <= 1'b1;
    end else if (tick_c && (ivl < INTERVAL_W'(TIMEOUT_TICKS))) begin
      ivl <= ivl + INTERVAL_W'(1);
    end
  end

  // Unused history slots are always zero, so summing every slot is exact.
  always_comb begin
    div_den = '0;
    for (int i = 0; i < int'(HIST_DEPTH); i++) div_den = div_den + SUM_W'(hist[i]);
  end

  assign div_num = NUM_W'(BPM_NUM) * NUM_W'(n);

  seq_divider #(
    .NUM_WIDTH (NUM_W),
    .DEN_WIDTH (SUM_W)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .num   (div_num),
    .den   (div_den),
    .busy  (div_busy),
    .done  (div_done),
    .quo   (div_quo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      for (int i = 0; i < int'(HIST_DEPTH); i++) hist[i] <= '0;
      n           <= '0;
      div_start   <= 1'b0;
      speed       <= SPEED_W'(BPM_RESET);
      speed_valid <= 1'b0;
      locked      <= 1'b0;
      tap_seen    <= 1'b0;
    end else begin
      speed_valid <= 1'b0;
      div_start   <= 1'b0;
      tap_seen    <= tap_acc_c;
      case (state)
        IDLE: begin
          if (tap_acc_c) state <= MEASURE;
        end
        MEASURE: begin
          if (tap_acc_c && (ivl < INTERVAL_W'(TIMEOUT_TICKS))) begin
            hist[0] <= ivl;
            for (int i = int'(HIST_DEPTH) - 1; i > 0; i--) hist[i] <= hist[i-1];
            if (n < N_W'(HIST_DEPTH)) n <= n + N_W'(1);
            div_start <= 1'b1;
            state     <= DIVIDE;
          end else if (ivl >= INTERVAL_W'(TIMEOUT_TICKS)) begin
            // Abandon the measurement; a tap landing on the timeout restarts timing.
            for (int i = 0; i < int'(HIST_DEPTH); i++) hist[i] <= '0;
            n      <= '0;
            locked <= 1'b0;
            state  <= tap_acc_c ? MEASURE : IDLE;
          end
        end
        DIVIDE: begin
          if (div_done) begin
            speed       <= clamp_bpm(div_quo, BPM_MIN, BPM_MAX);
            speed_valid <= 1'b1;
            locked      <= 1'b1;
            state       <= MEASURE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.speed       = speed;
  assign bus.speed_valid = speed_valid;
  assign bus.locked      = locked;
  assign bus.tap_seen    = tap_seen;

  // The lockout must outlast the divide so a tap never lands in DIVIDE.
  a_lockout_covers_divide: assert property (@(posedge clk) (DEBOUNCE_TICKS * PRESC) > 20);
  a_no_tap_in_divide: assert property (@(posedge clk) disable iff (rst)
                                       !(tap_acc_c && (state == DIVIDE)));
  a_div_start_free: assert property (@(posedge clk) disable iff (rst)
                                     div_start |-> !div_busy);

endmodule

// File: doc/tap_tempo.md
Name: tap_tempo

Overview:
- Tap-tempo detector: the inverse of the metronome path. It converts a user's tap pulses into a BPM value.
- A debounced tap input is timed in millisecond ticks. The last up to 4 intervals are averaged, and BPM = 60000·n / sum(intervals) is computed with a sequential divider.
- Output `speed` drives the same 8-bit speed bus the metronome consumes.

Parameters:
- CLK_HZ, 25_000_000, system clock frequency.
- TICK_HZ, 1000, measurement time base (1 tick = 1 ms).
- DEBOUNCE_TICKS, 10, lockout after an accepted tap; also the input stable time.
- TIMEOUT_TICKS, 2000, interval at which the measurement is abandoned (30 BPM floor).
- BPM_MIN, 30, lower clamp of the result.
- BPM_MAX, 250, upper clamp of the result.
- BPM_RESET, 60, reset/default speed.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- tap  in  1  raw tap button, asynchronous to clk.
- speed  out  8  measured BPM, clamped to BPM_MIN..BPM_MAX.
- speed_valid  out  1  one-cycle pulse when `speed` updates.
- locked  out  1  high once at least one interval has been measured; low after timeout.
- tap_seen  out  1  one-cycle pulse per accepted tap.

Behaviour:
- Reset values: speed=BPM_RESET; speed_valid=0; locked=0; tap_seen=0; state=IDLE; history and count cleared. Reset asserted mid-divide aborts the divide with no update.
- Input conditioning:
  - 2-flop synchronizer on `tap`, then rising-edge detect.
  - An edge is accepted only if DEBOUNCE_TICKS ticks have elapsed since the last accepted tap; otherwise it is ignored.
  - tap_seen pulses 3 cycles after the raw edge (2 sync flops + edge register).
- Tick generator: a prescaler counts 0..CLK_HZ/TICK_HZ-1 and emits a 1-cycle tick at wrap. It free-runs from reset.
- Interval counter: 11 bits, increments on each tick, saturates at TIMEOUT_TICKS, and clears to 0 on every accepted tap.
- FSM:
  - IDLE: accepted tap -> MEASURE (counter cleared).
  - MEASURE, accepted tap with counter < TIMEOUT_TICKS:
    - push the counter value into a 4-deep interval history (oldest dropped);
    - n = min(n+1, 4);
    - go to DIVIDE.
  - MEASURE, counter reaches TIMEOUT_TICKS:
    - go to IDLE; locked=0; history and n cleared;
    - `speed` holds its last value; no speed_valid.
  - DIVIDE: start the divider with numerator = 60·TICK_HZ·n (18 bits) and denominator = sum of the n history entries (13 bits). The interval counter keeps running.
  - On done: clamp the quotient, update `speed`, pulse speed_valid, set locked=1, go to MEASURE.
- Divide latency:
  - 18 cycles in the divider plus 1 cycle for clamp/register.
  - speed_valid fires exactly 20 cycles after the accepted tap edge is registered.
  - Parameters must give DEBOUNCE_TICKS·CLK_HZ/TICK_HZ > 20, so no tap can arrive during DIVIDE (assertion in RTL).
- Arithmetic:
  - Quotient is truncated (floor), not rounded.
  - Quotient < BPM_MIN -> BPM_MIN; quotient > BPM_MAX -> BPM_MAX.
  - A denominator of 0 cannot occur (interval ≥ DEBOUNCE_TICKS). If it does, the divider returns all-ones, which clamps to BPM_MAX.
- The first tap only starts timing: no speed_valid until the second tap.

Decomposition:
- Package tempo_pkg:
  - state enum {IDLE, MEASURE, DIVIDE};
  - widths INTERVAL_W=11, SUM_W=13, NUM_W=18;
  - constant HIST_DEPTH=4;
  - shared BPM_MIN/BPM_MAX/BPM_RESET defaults, which the speed-adjust block also uses.
- Sub-module seq_divider:
  - restoring, 1 quotient bit per cycle;
  - start/busy/done handshake;
  - parameterised numerator and denominator widths.

Test Plan:
Sim uses CLK_HZ=10_000, TICK_HZ=1000 (10 clk per tick).
- Reset, no taps -> speed=60, locked=0, no speed_valid for 30000 cycles.
- Taps every 500 ticks ×2 -> one speed_valid 20 cycles after the 2nd tap registers, speed=120, locked=1.
- Taps at intervals 400,400,400,600 -> successive speeds 150,150,150, then 60000·4/1800=133.
- Bouncing tap: pulses at +0,+3,+7 ticks, then a clean tap 1000 ticks later -> exactly 2 tap_seen pulses; speed=60.
- Interval 200 ticks -> 300 computed -> speed=250. Then no tap for 2000 ticks -> locked=0, speed stays 250; the next tap restarts from IDLE with no update.
- Assert rst 5 cycles into DIVIDE -> speed=60, locked=0, no speed_valid; normal operation after release.
